// File: rtl/dmem_access_ctrl.sv
// Load/store responder for local data memory: generates strided word addresses
// and moves beats to or from a single-port SRAM with 1-cycle read latency.
module dmem_access_ctrl #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              I_St_Req,
    input  logic              I_Ld_Req,
    input  logic [ADDR_W-1:0] I_Length,
    input  logic [ADDR_W-1:0] I_Stride,
    input  logic [ADDR_W-1:0] I_Base_Addr,
    input  logic              I_St_Valid,
    input  logic [DATA_W-1:0] I_St_Data,
    input  logic              I_Ld_Valid,
    output logic              O_St_Ready,
    output logic              O_Ld_Ready,
    output logic [DATA_W-1:0] O_Ld_Data,
    output logic              O_St_End_Access,
    output logic              O_Ld_End_Access,
    output logic              O_Stall,
    output logic              O_Addr_Err,
    output logic              O_Mem_Req,
    output logic              O_Mem_We,
    output logic [ADDR_W-1:0] O_Mem_Addr,
    output logic [DATA_W-1:0] O_Mem_WData,
    input  logic [DATA_W-1:0] I_Mem_RData,
    input  logic              I_Mem_Busy
);
    typedef enum logic [2:0] {IDLE, ST_RUN, LD_RUN, LD_DRAIN, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr, cnt, len, stride;
    logic              is_ld, zero_len, rd_pend, rd_oob;
    logic              in_range, st_beat, ld_beat, beat, last;

    assign in_range = 32'(addr) < 32'(MEM_DEPTH);
    assign st_beat  = (state == ST_RUN) && I_St_Valid && !I_Mem_Busy;
    assign ld_beat  = (state == LD_RUN) && I_Ld_Valid && !I_Mem_Busy;
    assign beat     = st_beat || ld_beat;
    assign last     = cnt == len - ADDR_W'(1);

    // SRAM port is driven in the beat cycle itself so stores sustain one word per cycle
    assign O_St_Ready  = (state == ST_RUN) && !I_Mem_Busy;
    assign O_Stall     = ((state == ST_RUN) || (state == LD_RUN)) && I_Mem_Busy;
    assign O_Mem_Req   = beat && in_range;
    assign O_Mem_We    = st_beat && in_range;
    assign O_Mem_Addr  = O_Mem_Req ? addr : '0;
    assign O_Mem_WData = O_Mem_We ? I_St_Data : '0;
    assign O_Addr_Err  = beat && !in_range;

    // Read data is taken straight from the SRAM output register the cycle after issue
    assign O_Ld_Ready      = rd_pend;
    assign O_Ld_Data       = (rd_pend && !rd_oob) ? I_Mem_RData : '0;
    assign O_St_End_Access = (state == DONE) && !is_ld;
    assign O_Ld_End_Access = (state == LD_DRAIN) || ((state == DONE) && is_ld && zero_len);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            addr     <= '0;
            cnt      <= '0;
            len      <= '0;
            stride   <= '0;
            is_ld    <= 1'b0;
            zero_len <= 1'b0;
            rd_pend  <= 1'b0;
            rd_oob   <= 1'b0;
        end else begin
            rd_pend <= ld_beat;
            rd_oob  <= ld_beat && !in_range;
            case (state)
                IDLE: begin
                    if (I_St_Req || I_Ld_Req) begin
                        len      <= I_Length;
                        stride   <= I_Stride;
                        addr     <= I_Base_Addr;
                        cnt      <= '0;
                        is_ld    <= !I_St_Req;
                        zero_len <= I_Length == '0;
                        if (I_Length == '0) state <= DONE;
                        else if (I_St_Req)  state <= ST_RUN;
                        else                state <= LD_RUN;
                    end
                end
                ST_RUN, LD_RUN: begin
                    if (beat) begin
                        addr <= addr + stride;
                        cnt  <= cnt + ADDR_W'(1);
                        if (last) state <= (state == ST_RUN) ? DONE : LD_DRAIN;
                    end
                end
                LD_DRAIN: state <= DONE;
                DONE:     state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a behavioural 1-cycle-latency SRAM.
module tb_dmem_access_ctrl;
    logic        clock = 1'b0;
    logic        reset;
    logic        I_St_Req, I_Ld_Req, I_St_Valid, I_Ld_Valid, I_Mem_Busy;
    logic [15:0] I_Length, I_Stride, I_Base_Addr;
    logic [31:0] I_St_Data, I_Mem_RData;
    logic        O_St_Ready, O_Ld_Ready, O_St_End_Access, O_Ld_End_Access;
    logic        O_Stall, O_Addr_Err, O_Mem_Req, O_Mem_We;
    logic [31:0] O_Ld_Data, O_Mem_WData;
    logic [15:0] O_Mem_Addr;

    int checks = 0;
    int passed = 0;
    int mem_acc = 0;
    logic [31:0] mem [0:1023];
    logic [31:0] wdat [0:7];
    logic [31:0] rexp [0:7];

    always #5 clock = ~clock;

    dmem_access_ctrl dut (
        .clock(clock), .reset(reset),
        .I_St_Req(I_St_Req), .I_Ld_Req(I_Ld_Req),
        .I_Length(I_Length), .I_Stride(I_Stride), .I_Base_Addr(I_Base_Addr),
        .I_St_Valid(I_St_Valid), .I_St_Data(I_St_Data), .I_Ld_Valid(I_Ld_Valid),
        .O_St_Ready(O_St_Ready), .O_Ld_Ready(O_Ld_Ready), .O_Ld_Data(O_Ld_Data),
        .O_St_End_Access(O_St_End_Access), .O_Ld_End_Access(O_Ld_End_Access),
        .O_Stall(O_Stall), .O_Addr_Err(O_Addr_Err),
        .O_Mem_Req(O_Mem_Req), .O_Mem_We(O_Mem_We), .O_Mem_Addr(O_Mem_Addr),
        .O_Mem_WData(O_Mem_WData), .I_Mem_RData(I_Mem_RData), .I_Mem_Busy(I_Mem_Busy)
    );

    always @(posedge clock) begin
        if (O_Mem_Req) begin
            mem_acc <= mem_acc + 1;
            if (O_Mem_We) mem[O_Mem_Addr[9:0]] <= O_Mem_WData;
            else          I_Mem_RData <= mem[O_Mem_Addr[9:0]];
        end
    end

    task automatic test_reset();
        reset = 1'b0;
        {I_St_Req, I_Ld_Req, I_St_Valid, I_Ld_Valid, I_Mem_Busy} = '0;
        I_Length = '0; I_Stride = '0; I_Base_Addr = '0; I_St_Data = '0;
        repeat (2) @(negedge clock);
        #1;
        checks++;
        if ({O_St_Ready, O_Ld_Ready, O_St_End_Access, O_Ld_End_Access, O_Stall,
             O_Addr_Err, O_Mem_Req, O_Mem_We} !== 8'h00)
            $display("FAIL reset_ctl: got %b want 00000000", {O_St_Ready, O_Ld_Ready,
                     O_St_End_Access, O_Ld_End_Access, O_Stall, O_Addr_Err, O_Mem_Req, O_Mem_We});
        else passed++;
        checks++;
        if ({O_Ld_Data, O_Mem_WData, O_Mem_Addr} !== 80'h0)
            $display("FAIL reset_data: got %h want 0", {O_Ld_Data, O_Mem_WData, O_Mem_Addr});
        else passed++;
        reset = 1'b1;
    endtask

    // Store transaction; ld_too raises the load request in the same cycle and leaves it held.
    task automatic do_store(input logic [15:0] base, input logic [15:0] stride,
                            input int len, input logic ld_too);
        logic [15:0] a;
        @(negedge clock);
        I_St_Req = 1'b1; I_Ld_Req = ld_too; I_Length = 16'(len); I_Stride = stride;
        I_Base_Addr = base; I_St_Valid = 1'b1; I_St_Data = wdat[0];
        #1;
        checks++;
        if (O_Mem_Req !== 1'b0) $display("FAIL st_idle_req: got %b want 0", O_Mem_Req);
        else passed++;
        for (int i = 0; i < len; i++) begin
            @(negedge clock);
            I_St_Data = wdat[i];
            a = base + 16'(i) * stride;
            #1;
            checks++;
            if ({O_Mem_Req, O_Mem_We, O_St_Ready, O_Mem_Addr, O_Mem_WData, O_St_End_Access}
                !== {3'b111, a, wdat[i], 1'b0})
                $display("FAIL st_beat%0d: got req%b we%b rdy%b addr %h data %h end%b want 111 %h %h 0",
                         i, O_Mem_Req, O_Mem_We, O_St_Ready, O_Mem_Addr, O_Mem_WData,
                         O_St_End_Access, a, wdat[i]);
            else passed++;
        end
        @(negedge clock);
        I_St_Valid = 1'b0;
        #1;
        checks++;
        if ({O_St_End_Access, O_Ld_End_Access, O_Mem_Req} !== 3'b100)
            $display("FAIL st_end: got st%b ld%b req%b want 100",
                     O_St_End_Access, O_Ld_End_Access, O_Mem_Req);
        else passed++;
        I_St_Req = 1'b0;
    endtask

    // Load transaction; expected data comes from rexp[], out-of-range beats expect 0.
    task automatic do_load(input logic [15:0] base, input logic [15:0] stride, input int len);
        logic [15:0] a;
        logic        prev_ok = 1'b0;
        @(negedge clock);
        I_Ld_Req = 1'b1; I_Length = 16'(len); I_Stride = stride;
        I_Base_Addr = base; I_Ld_Valid = 1'b1;
        #1;
        checks++;
        if (O_Ld_Ready !== 1'b0) $display("FAIL ld_idle_rdy: got %b want 0", O_Ld_Ready);
        else passed++;
        for (int i = 0; i < len; i++) begin
            @(negedge clock);
            a = base + 16'(i) * stride;
            #1;
            checks++;
            if (a < 16'd1024) begin
                if ({O_Mem_Req, O_Mem_We, O_Addr_Err, O_Mem_Addr} !== {3'b100, a})
                    $display("FAIL ld_issue%0d: got req%b we%b err%b addr %h want 100 %h",
                             i, O_Mem_Req, O_Mem_We, O_Addr_Err, O_Mem_Addr, a);
                else passed++;
            end else begin
                if ({O_Mem_Req, O_Addr_Err} !== 2'b01)
                    $display("FAIL ld_oob%0d: got req%b err%b want 01", i, O_Mem_Req, O_Addr_Err);
                else passed++;
            end
            if (i > 0) begin
                checks++;
                if ({O_Ld_Ready, O_Ld_End_Access, O_Ld_Data} !== {2'b10, prev_ok ? rexp[i-1] : 32'h0})
                    $display("FAIL ld_data%0d: got rdy%b end%b %h want 10 %h", i - 1, O_Ld_Ready,
                             O_Ld_End_Access, O_Ld_Data, prev_ok ? rexp[i-1] : 32'h0);
                else passed++;
            end
            prev_ok = a < 16'd1024;
        end
        @(negedge clock);
        I_Ld_Valid = 1'b0;
        #1;
        checks++;
        if ({O_Ld_Ready, O_Ld_End_Access, O_Ld_Data} !== {2'b11, prev_ok ? rexp[len-1] : 32'h0})
            $display("FAIL ld_last: got rdy%b end%b %h want 11 %h", O_Ld_Ready, O_Ld_End_Access,
                     O_Ld_Data, prev_ok ? rexp[len-1] : 32'h0);
        else passed++;
        I_Ld_Req = 1'b0;
        @(negedge clock);
        #1;
        checks++;
        if ({O_Ld_Ready, O_Ld_End_Access, O_St_End_Access} !== 3'b000)
            $display("FAIL ld_done: got rdy%b ldend%b stend%b want 000",
                     O_Ld_Ready, O_Ld_End_Access, O_St_End_Access);
        else passed++;
    endtask

    task automatic test_store();
        wdat[0] = 32'hAAAA_0001; wdat[1] = 32'hBBBB_0002;
        wdat[2] = 32'hCCCC_0003; wdat[3] = 32'hDDDD_0004;
        do_store(16'h0010, 16'd2, 4, 1'b0);
        rexp[0] = 32'hAAAA_0001; rexp[1] = 32'hBBBB_0002;
        rexp[2] = 32'hCCCC_0003; rexp[3] = 32'hDDDD_0004;
        do_load(16'h0010, 16'd2, 4);
    endtask

    task automatic test_simultaneous_load();
        wdat[0] = 32'h1111_0012; wdat[1] = 32'h2222_0013; wdat[2] = 32'h3333_0014;
        do_store(16'h0012, 16'd1, 3, 1'b1);
        rexp[0] = 32'h1111_0012; rexp[1] = 32'h2222_0013; rexp[2] = 32'h3333_0014;
        do_load(16'h0012, 16'd1, 3);
    endtask

    task automatic test_busy();
        @(negedge clock);
        I_St_Req = 1'b1; I_Length = 16'd4; I_Stride = 16'd1; I_Base_Addr = 16'h0040;
        I_St_Valid = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clock);
            I_Mem_Busy = (c == 1 || c == 2);
            I_St_Data = 32'h5000_0000 + 32'(c);
            #1;
            checks++;
            if (c == 1 || c == 2) begin
                if ({O_St_Ready, O_Stall, O_Mem_Req, O_St_End_Access} !== 4'b0100)
                    $display("FAIL busy_c%0d: got rdy%b stall%b req%b end%b want 0100",
                             c, O_St_Ready, O_Stall, O_Mem_Req, O_St_End_Access);
                else passed++;
            end else if (c < 6) begin
                if ({O_St_Ready, O_Stall, O_Mem_Req, O_St_End_Access, O_Mem_Addr}
                    !== {4'b1010, 16'h0040 + 16'(c == 0 ? 0 : c - 2)})
                    $display("FAIL busy_beat_c%0d: got rdy%b stall%b req%b end%b addr %h",
                             c, O_St_Ready, O_Stall, O_Mem_Req, O_St_End_Access, O_Mem_Addr);
                else passed++;
            end else begin
                if ({O_St_End_Access, O_Mem_Req} !== 2'b10)
                    $display("FAIL busy_end: got end%b req%b want 10", O_St_End_Access, O_Mem_Req);
                else passed++;
                I_St_Req = 1'b0; I_St_Valid = 1'b0;
            end
        end
        rexp[0] = 32'h5000_0000; rexp[1] = 32'h5000_0003;
        rexp[2] = 32'h5000_0004; rexp[3] = 32'h5000_0005;
        do_load(16'h0040, 16'd1, 4);
    endtask

    task automatic test_boundary();
        wdat[0] = 32'hBEEF_03FF;
        do_store(16'd1023, 16'd1, 1, 1'b0);
        rexp[0] = 32'hBEEF_03FF;
        do_load(16'd1023, 16'd1, 2);
    endtask

    task automatic test_zero_len();
        int acc0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            acc0 = mem_acc;
            I_St_Req = (k == 0); I_Ld_Req = (k == 1); I_Length = '0; I_Base_Addr = 16'h0020;
            #1;
            checks++;
            if ({O_St_End_Access, O_Ld_End_Access} !== 2'b00)
                $display("FAIL zero%0d_req: got st%b ld%b want 00", k, O_St_End_Access, O_Ld_End_Access);
            else passed++;
            @(negedge clock);
            #1;
            checks++;
            if ({O_St_End_Access, O_Ld_End_Access, O_Mem_Req} !== {k == 0, k == 1, 1'b0})
                $display("FAIL zero%0d_end: got st%b ld%b req%b", k, O_St_End_Access,
                         O_Ld_End_Access, O_Mem_Req);
            else passed++;
            I_St_Req = 1'b0; I_Ld_Req = 1'b0;
            @(negedge clock);
            #1;
            checks++;
            if ({O_St_End_Access, O_Ld_End_Access, 32'(mem_acc)} !== {2'b00, 32'(acc0)})
                $display("FAIL zero%0d_after: got st%b ld%b acc %0d want 00 acc %0d", k,
                         O_St_End_Access, O_Ld_End_Access, mem_acc, acc0);
            else passed++;
        end
    endtask

    task automatic test_reset_mid_load();
        @(negedge clock);
        I_Ld_Req = 1'b1; I_Length = 16'd3; I_Stride = 16'd1; I_Base_Addr = 16'h0012;
        I_Ld_Valid = 1'b1;
        @(negedge clock);
        #1;
        checks++;
        if (O_Mem_Req !== 1'b1) $display("FAIL rst_beat0: got req%b want 1", O_Mem_Req);
        else passed++;
        @(negedge clock);
        reset = 1'b0; I_Ld_Req = 1'b0; I_Ld_Valid = 1'b0;
        @(negedge clock);
        #1;
        checks++;
        if ({O_St_Ready, O_Ld_Ready, O_St_End_Access, O_Ld_End_Access, O_Stall,
             O_Addr_Err, O_Mem_Req, O_Mem_We, O_Ld_Data, O_Mem_Addr, O_Mem_WData} !== '0)
            $display("FAIL rst_outputs: rdy%b ldend%b req%b data %h want all 0",
                     O_Ld_Ready, O_Ld_End_Access, O_Mem_Req, O_Ld_Data);
        else passed++;
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            #1;
            checks++;
            if ({O_Ld_End_Access, O_St_End_Access, O_Ld_Ready, O_Mem_Req} !== 4'b0000)
                $display("FAIL rst_after%0d: got ldend%b stend%b rdy%b req%b want 0000", c,
                         O_Ld_End_Access, O_St_End_Access, O_Ld_Ready, O_Mem_Req);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_store();
        test_simultaneous_load();
        test_busy();
        test_boundary();
        test_zero_len();
        test_reset_mid_load();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, checks);
        $fatal(1);
    end
endmodule
